bus_matrix_wrr_arbiter: RTL and testbench

Next-generation per-slave arbiter for the bus matrix. It selects one of N_REQ masters for a slave port using fixed-priority, true round-robin or weighted round-robin arbitration. A grant is held for a whole transaction or a locked burst. The grant output is registered with one cycle of latency, and back-to-back grants have no bubble.

---
 rtl/bus_matrix_pkg.sv | 19 +
 rtl/bus_matrix_wrr_arbiter_if.sv | 26 ++
 rtl/bus_matrix_rr_pick.sv | 34 +++
 rtl/bus_matrix_wrr_arbiter.sv | 138 +++++++++++++
 tb/tb_bus_matrix_wrr_arbiter.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/bus_matrix_pkg.sv
// Shared bus-matrix types: arbitration schemes, arbiter FSM states and index-width helper.
package bus_matrix_pkg;

  typedef enum logic [1:0] {
    ARB_FIXED = 2'd0,
    ARB_RR    = 2'd1,
    ARB_WRR   = 2'd2
  } arb_scheme_e;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_matrix_wrr_arbiter_if.sv
// Request/grant bundle between the masters of one slave port and its arbiter.
interface bus_matrix_wrr_arbiter_if #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned WEIGHT_W = 4
);
  localparam int unsigned IDX_W = bus_matrix_pkg::idx_width(N_REQ);

  logic [N_REQ-1:0]          req_i;
  logic [N_REQ-1:0]          lock_i;
  logic                      done_i;
  logic [N_REQ*WEIGHT_W-1:0] weight_i;
  logic [N_REQ-1:0]          gnt_o;
  logic [IDX_W-1:0]          gnt_idx_o;
  logic                      gnt_valid_o;
  logic                      timeout_o;

  modport master (
    output req_i, lock_i, done_i, weight_i,
    input  gnt_o, gnt_idx_o, gnt_valid_o, timeout_o
  );

  modport slave (
    input  req_i, lock_i, done_i, weight_i,
    output gnt_o, gnt_idx_o, gnt_valid_o, timeout_o
  );
endinterface

// File: rtl/bus_matrix_rr_pick.sv
// Rotating priority encoder: first available request at or above ptr_i, wrapping.
module bus_matrix_rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  input  logic [N_REQ-1:0] excl_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);
  logic [N_REQ-1:0]   avail;
  logic [2*N_REQ-1:0] masked;
  logic               found;

  // Upper copy of the doubled vector supplies the wrapped-around requests.
  assign avail  = req_i & ~excl_i;
  assign masked = {avail, avail} & ({(2*N_REQ){1'b1}} << ptr_i);

  always_comb begin
    idx_o = '0;
    found = 1'b0;
    for (int unsigned j = 0; j < 2*N_REQ; j++) begin
      if (!found && masked[j]) begin
        found = 1'b1;
        idx_o = IDX_W'(j % N_REQ);
      end
    end
  end

  assign any_o = |avail;
  assign gnt_o = any_o ? (N_REQ'(1) << idx_o) : '0;
endmodule

// File: rtl/bus_matrix_wrr_arbiter.sv
// Per-slave fixed / round-robin / weighted round-robin arbiter with registered one-hot grant.
// Optional forced release of over-long locked grants: BUS_MATRIX_ARB_TIMEOUT_EN.
module bus_matrix_wrr_arbiter
  import bus_matrix_pkg::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter arb_scheme_e SCHEME   = ARB_RR,
  parameter int unsigned WEIGHT_W = 4,
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic clk,
  input  logic rst,
  bus_matrix_wrr_arbiter_if.slave bus
);
  localparam int unsigned IDX_W = idx_width(N_REQ);

  arb_state_e          state_q, state_d;
  logic [N_REQ-1:0]    gnt_q, gnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d, ptr_q, ptr_d;
  logic [WEIGHT_W-1:0] credit_q, credit_d;
  logic [IDX_W-1:0]    ptr_rel, pick_ptr, pick_idx;
  logic [N_REQ-1:0]    pick_excl, pick_gnt;
  logic                pick_any, release_req, force_rel, new_grant;
  logic [WEIGHT_W-1:0] pick_weight, credit_load;

  // On a release the next pick already sees the advanced pointer and skips the releaser.
  assign ptr_rel   = (SCHEME == ARB_FIXED || idx_q == IDX_W'(N_REQ-1)) ? '0 : idx_q + IDX_W'(1);
  assign pick_ptr  = (state_q == GRANT) ? ptr_rel : ptr_q;
  assign pick_excl = (state_q == GRANT) ? gnt_q : '0;

  bus_matrix_rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
    .req_i  (bus.req_i),
    .ptr_i  (pick_ptr),
    .excl_i (pick_excl),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  assign pick_weight = bus.weight_i[pick_idx*WEIGHT_W +: WEIGHT_W];
  assign credit_load = (SCHEME != ARB_WRR || pick_weight == '0) ? WEIGHT_W'(1) : pick_weight;

`ifdef BUS_MATRIX_ARB_TIMEOUT_EN
  localparam int unsigned HOLD_W = $clog2(HOLD_MAX + 1);
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              timeout_q;

  assign force_rel = (state_q == GRANT) && (hold_q == HOLD_W'(HOLD_MAX - 1));

  always_comb begin
    hold_d = hold_q;
    if (new_grant)
      hold_d = '0;
    else if (state_q == GRANT && hold_q != '1)
      hold_d = hold_q + HOLD_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= force_rel;
    end
  end

  assign bus.timeout_o = timeout_q;
`else
  assign force_rel     = 1'b0;
  assign bus.timeout_o = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    idx_d       = idx_q;
    credit_d    = credit_q;
    ptr_d       = ptr_q;
    new_grant   = 1'b0;
    release_req = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d   = GRANT;
          new_grant = 1'b1;
        end
      end
      GRANT: begin
        // A dropped request outranks lock and remaining credit.
        if (!bus.req_i[idx_q]) begin
          release_req = 1'b1;
        end else if (bus.done_i && !bus.lock_i[idx_q]) begin
          if (SCHEME == ARB_WRR && credit_q > WEIGHT_W'(1))
            credit_d = credit_q - WEIGHT_W'(1);
          else
            release_req = 1'b1;
        end
        if (release_req || force_rel) begin
          ptr_d = ptr_rel;
          if (pick_any) begin
            new_grant = 1'b1;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            idx_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (new_grant) begin
      gnt_d    = pick_gnt;
      idx_d    = pick_idx;
      credit_d = credit_load;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      idx_q    <= '0;
      credit_q <= '0;
      ptr_q    <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      idx_q    <= idx_d;
      credit_q <= credit_d;
      ptr_q    <= ptr_d;
    end
  end

  assign bus.gnt_o       = gnt_q;
  assign bus.gnt_idx_o   = idx_q;
  assign bus.gnt_valid_o = |gnt_q;
endmodule

// File: tb/tb_bus_matrix_wrr_arbiter.sv
// Checks fixed, RR and WRR arbiter instances against a cycle-level reference model.
// Timeout behaviour is also modelled when BUS_MATRIX_ARB_TIMEOUT_EN is defined.
module tb_bus_matrix_wrr_arbiter;
  import bus_matrix_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned WW = 4;
  localparam int unsigned HM = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    req    = '0;
  logic [N-1:0]    lock   = '0;
  logic            done   = 1'b0;
  logic [N*WW-1:0] weight = '0;

  bus_matrix_wrr_arbiter_if #(.N_REQ(N), .WEIGHT_W(WW)) if_fx(), if_rr(), if_wrr();

  assign if_fx.req_i  = req;  assign if_fx.lock_i  = lock;  assign if_fx.done_i  = done;  assign if_fx.weight_i  = weight;
  assign if_rr.req_i  = req;  assign if_rr.lock_i  = lock;  assign if_rr.done_i  = done;  assign if_rr.weight_i  = weight;
  assign if_wrr.req_i = req;  assign if_wrr.lock_i = lock;  assign if_wrr.done_i = done;  assign if_wrr.weight_i = weight;

  bus_matrix_wrr_arbiter #(.N_REQ(N), .SCHEME(ARB_FIXED), .WEIGHT_W(WW), .HOLD_MAX(HM))
    u_fx (.clk(clk), .rst(rst), .bus(if_fx));
  bus_matrix_wrr_arbiter #(.N_REQ(N), .SCHEME(ARB_RR), .WEIGHT_W(WW), .HOLD_MAX(HM))
    u_rr (.clk(clk), .rst(rst), .bus(if_rr));
  bus_matrix_wrr_arbiter #(.N_REQ(N), .SCHEME(ARB_WRR), .WEIGHT_W(WW), .HOLD_MAX(HM))
    u_wrr (.clk(clk), .rst(rst), .bus(if_wrr));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference state per scheme (0 fixed, 1 rr, 2 wrr); owner -1 means no grant.
  int m_g[3];
  int m_ptr[3];
  int m_credit[3];
  int m_age[3];
  int m_to[3];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int find_next(input logic [N-1:0] r, input int start, input int skip);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (start + k) % N;
      if (i != skip && r[i]) return i;
    end
    return -1;
  endfunction

  task automatic grant_to(input int s, input int p);
    int w;
    w = int'((weight >> (p*WW)) & ((1 << WW) - 1));
    m_g[s]      = p;
    m_age[s]    = 1;
    m_credit[s] = (s == 2) ? ((w == 0) ? 1 : w) : 1;
  endtask

  task automatic model_step(input int s);
    int g, p;
    bit rel, forced;
    if (rst) begin
      m_g[s] = -1; m_ptr[s] = 0; m_credit[s] = 0; m_age[s] = 0; m_to[s] = 0;
      return;
    end
    m_to[s] = 0;
    if (m_g[s] < 0) begin
      p = find_next(req, m_ptr[s], -1);
      if (p >= 0) grant_to(s, p);
      return;
    end
    g = m_g[s];
    forced = 1'b0;
`ifdef BUS_MATRIX_ARB_TIMEOUT_EN
    forced = (m_age[s] >= HM);
`endif
    rel = 1'b0;
    if (!req[g]) rel = 1'b1;
    else if (done && !lock[g]) begin
      if (s == 2 && m_credit[s] > 1) m_credit[s]--;
      else rel = 1'b1;
    end
    if (rel || forced) begin
      m_to[s]  = forced ? 1 : 0;
      m_ptr[s] = (s == 0) ? 0 : (g + 1) % N;
      p = find_next(req, m_ptr[s], g);
      if (p >= 0) grant_to(s, p);
      else m_g[s] = -1;
    end else begin
      m_age[s]++;
    end
  endtask

  task automatic check_out(input int s, input logic [N-1:0] g, input logic [1:0] ix,
                           input logic v, input logic to);
    string nm;
    int eg, ei, ev;
    nm = (s == 0) ? "fixed" : (s == 1) ? "rr" : "wrr";
    eg = (m_g[s] < 0) ? 0 : (1 << m_g[s]);
    ei = (m_g[s] < 0) ? 0 : m_g[s];
    ev = (m_g[s] < 0) ? 0 : 1;
    check_eq($sformatf("%s.gnt c%0d", nm, cyc),     32'(g),  32'(eg));
    check_eq($sformatf("%s.idx c%0d", nm, cyc),     32'(ix), 32'(ei));
    check_eq($sformatf("%s.valid c%0d", nm, cyc),   32'(v),  32'(ev));
    check_eq($sformatf("%s.timeout c%0d", nm, cyc), 32'(to), 32'(m_to[s]));
  endtask

  task automatic cycle();
    @(posedge clk);
    for (int s = 0; s < 3; s++) model_step(s);
    cyc++;
    #1;
    check_out(0, if_fx.gnt_o,  if_fx.gnt_idx_o,  if_fx.gnt_valid_o,  if_fx.timeout_o);
    check_out(1, if_rr.gnt_o,  if_rr.gnt_idx_o,  if_rr.gnt_valid_o,  if_rr.timeout_o);
    check_out(2, if_wrr.gnt_o, if_wrr.gnt_idx_o, if_wrr.gnt_valid_o, if_wrr.timeout_o);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    weight = {4'd1, 4'd1, 4'd3, 4'd1};
    rst = 1'b1; run(2);
    rst = 1'b0;

    req = 4'b1010; done = 1'b1; run(6);
    req = 4'b1111; run(6);

    rst = 1'b1; run(1); rst = 1'b0;
    req = 4'b0011; run(9);

    req = 4'b0101; lock = 4'b0100; run(10);
    lock = 4'b0000; run(4);

`ifdef BUS_MATRIX_ARB_TIMEOUT_EN
    rst = 1'b1; run(1); rst = 1'b0;
    req = 4'b0011; lock = 4'b0010; run(40);
    lock = 4'b0000;
`endif

    req = 4'b1111; done = 1'b0; run(3);
    rst = 1'b1; run(1); rst = 1'b0;
    req = 4'b1000; run(2);
    req = 4'b1111; done = 1'b1; run(6);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      lock   = 4'($urandom) & 4'($urandom) & 4'($urandom);
      done   = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 15) == 0) weight = 16'($urandom);
      rst    = ($urandom_range(0, 199) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
